// File: rtl/queue_ctrl_pkg.sv
// rtl/queue_ctrl_pkg.sv - shared types, defaults and round-robin pick helper for the queue front end
package queue_ctrl_pkg;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_WIDTH = 67;
    localparam int DEF_ID_W       = $clog2(DEF_NUM_REQ);
    localparam int MAX_REQ        = 16;

    typedef struct packed {
        logic [DEF_ID_W-1:0]       src;
        logic [DEF_DATA_WIDTH-1:0] data;
    } entry_t;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } pick_t;

    function automatic int entry_width(input int num_req, input int data_width);
        return data_width + $clog2(num_req);
    endfunction

    // Walks from the farthest offset back to the pointer so the last hit is the first in rr order.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                      input logic [3:0]         ptr,
                                      input int                 num_req);
        pick_t p;
        int    j;
        p = '0;
        for (int i = MAX_REQ - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= num_req) j = j - num_req;
            if (i < num_req && req[4'(j)]) begin
                p.found = 1'b1;
                p.idx   = 4'(j);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with its rotating priority pointer
module rr_arbiter
    import queue_ctrl_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               block,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    idx
);

    logic [ID_W-1:0]    rr_ptr;
    logic [MAX_REQ-1:0] req_ext;
    pick_t              pick;

    always_comb begin
        req_ext              = '0;
        req_ext[NUM_REQ-1:0] = req;
        pick                 = rr_pick(req_ext, 4'(rr_ptr), NUM_REQ);
        idx                  = ID_W'(pick.idx);
        gnt                  = '0;
        if (pick.found && !block && rst_n) gnt[idx] = 1'b1;
    end

    // Explicit wrap keeps non-power-of-two NUM_REQ from landing on an unused index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (|gnt) begin
            rr_ptr <= (idx == ID_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/queue_rr_ctrl.sv
// rtl/queue_rr_ctrl.sv - arbitrates producers onto the queue write port and streams its read port out
module queue_rr_ctrl
    import queue_ctrl_pkg::*;
#(
    parameter  int NUM_REQ     = DEF_NUM_REQ,
    parameter  int DATA_WIDTH  = DEF_DATA_WIDTH,
    localparam int ID_W        = $clog2(NUM_REQ),
    localparam int QUEUE_WIDTH = entry_width(NUM_REQ, DATA_WIDTH)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          q_wen,
    output logic [QUEUE_WIDTH-1:0]        q_din,
    input  logic                          q_full,
    output logic                          q_ren,
    input  logic                          q_empty,
    input  logic [QUEUE_WIDTH-1:0]        q_dout,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [ID_W-1:0]               out_src,
    input  logic                          out_ready
);

    logic [ID_W-1:0]        arb_idx;
    logic [QUEUE_WIDTH-1:0] skid [2];
    logic                   rd_idx;
    logic                   wr_idx;
    logic [1:0]             occ;
    logic [1:0]             occ_next;
    logic                   inflight;
    logic                   pop;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .block (q_full),
        .gnt   (gnt),
        .idx   (arb_idx)
    );

    always_comb begin
        q_wen = |gnt;
        q_din = {arb_idx, req_data[int'(arb_idx)*DATA_WIDTH +: DATA_WIDTH]};
    end

    // Reads are issued only when the word they return is guaranteed a skid slot.
    always_comb begin
        out_valid = (occ != 2'd0);
        pop       = out_valid && out_ready;
        occ_next  = occ + 2'(inflight) - 2'(pop);
        q_ren     = rst_n && !q_empty && !occ_next[1];
        out_data  = skid[rd_idx][DATA_WIDTH-1:0];
        out_src   = skid[rd_idx][QUEUE_WIDTH-1 -: ID_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid[0]  <= '0;
            skid[1]  <= '0;
            rd_idx   <= 1'b0;
            wr_idx   <= 1'b0;
            occ      <= 2'd0;
            inflight <= 1'b0;
        end else begin
            inflight <= q_ren;
            occ      <= occ_next;
            if (inflight) begin
                skid[wr_idx] <= q_dout;
                wr_idx       <= ~wr_idx;
            end
            if (pop) rd_idx <= ~rd_idx;
        end
    end

endmodule
